// File: rtl/div_ctrl_pkg.sv
// rtl/div_ctrl_pkg.sv - shared types, constants and helpers for the divide sequencer
package div_ctrl_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam int DIV_ITERS = 32;
  localparam int DIV_CNT_W = 5;
  localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(DIV_ITERS - 1);

  // Funct codes from the main decoder that select signed_i
  localparam logic [5:0] EXE_DIV  = 6'b011010;
  localparam logic [5:0] EXE_DIVU = 6'b011011;

  // Two's-complement negate
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  // Magnitude of an operand; unsigned operands pass through untouched
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? neg32(v) : v;
  endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// rtl/div_ctrl_if.sv - request/result bundle between EX stage and divide sequencer
interface div_ctrl_if;
  logic        start_i;
  logic        signed_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stall_o;

  // EX-stage requester side
  modport master (
    output start_i, signed_i, opdata1_i, opdata2_i, annul_i,
    input  result_o, ready_o, stall_o
  );

  // Divider side
  modport slave (
    input  start_i, signed_i, opdata1_i, opdata2_i, annul_i,
    output result_o, ready_o, stall_o
  );
endinterface

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - 32-iteration restoring divide sequencer with flush and stall
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  div_ctrl_if.slave   div
);

  div_state_e           state_q, state_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]          rem_q, rem_d;
  logic [31:0]          quo_q, quo_d;
  logic [31:0]          dvsr_q, dvsr_d;
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;

  logic [32:0]          partial;
  logic [32:0]          diff;
  logic [31:0]          rem_step;
  logic [31:0]          quo_step;

  // One restoring step: the dividend is shifted out of quo into a 33-bit partial remainder
  always_comb begin
    partial  = {rem_q, quo_q[31]};
    diff     = partial - {1'b0, dvsr_q};
    rem_step = diff[32] ? partial[31:0] : diff[31:0];
    quo_step = {quo_q[30:0], ~diff[32]};
  end

  // Next-state, counter and datapath register updates
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;

    case (state_q)
      DIV_FREE: begin
        if (div.start_i && !div.annul_i) begin
          neg_quo_d = div.signed_i & (div.opdata1_i[31] ^ div.opdata2_i[31]);
          neg_rem_d = div.signed_i & div.opdata1_i[31];
          rem_d     = '0;
          quo_d     = abs32(div.opdata1_i, div.signed_i);
          dvsr_d    = abs32(div.opdata2_i, div.signed_i);
          cnt_d     = '0;
          state_d   = (div.opdata2_i == 32'd0) ? DIV_BYZERO : DIV_ON;
        end
      end
      DIV_BYZERO: begin
        rem_d   = '0;
        quo_d   = '0;
        state_d = DIV_END;
      end
      DIV_ON: begin
        cnt_d = cnt_q + DIV_CNT_W'(1);
        if (cnt_q == DIV_LAST) begin
          // Final step also applies the sign fixup so END holds the architectural result
          quo_d   = neg_quo_q ? neg32(quo_step) : quo_step;
          rem_d   = neg_rem_q ? neg32(rem_step) : rem_step;
          state_d = DIV_END;
        end else begin
          quo_d = quo_step;
          rem_d = rem_step;
        end
      end
      DIV_END: begin
        if (!div.start_i) begin
          state_d = DIV_FREE;
        end
      end
      default: state_d = DIV_FREE;
    endcase

    // A flush abandons whatever is in flight
    if (div.annul_i) begin
      state_d = DIV_FREE;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= DIV_FREE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  // Outputs are combinational so a flush or a fresh request takes effect in the same cycle
  always_comb begin
    div.ready_o  = (state_q == DIV_END) && !div.annul_i;
    div.stall_o  = div.start_i && !div.annul_i && (state_q != DIV_END);
    div.result_o = div.ready_o ? {rem_q, quo_q} : 64'd0;
  end

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - directed self-checking bench for the divide sequencer
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  logic clk;
  logic resetn;
  int   n_checks;
  int   n_errors;

  div_ctrl_if bus ();

  div_ctrl dut (
    .clk    (clk),
    .resetn (resetn),
    .div    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [65:0] outs();
    return {bus.ready_o, bus.stall_o, bus.result_o};
  endfunction

  // Issue one divide at cycle 0, check busy cycles, result at cycle lat, optional hold, then release
  task automatic do_div(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int lat, input int hold);
    int ok_cycles;
    ok_cycles = 0;
    @(posedge clk); #1;
    bus.start_i   = 1'b1;
    bus.signed_i  = sgn;
    bus.opdata1_i = a;
    bus.opdata2_i = b;
    #1;
    if (bus.stall_o && !bus.ready_o && bus.result_o == 64'd0) ok_cycles++;
    for (int c = 1; c < lat; c++) begin
      @(posedge clk); #2;
      if (bus.stall_o && !bus.ready_o && bus.result_o == 64'd0) ok_cycles++;
    end
    check_eq({tag, "_busy"}, 66'(ok_cycles), 66'(lat));
    @(posedge clk); #2;
    check_eq({tag, "_result"}, outs(), {1'b1, 1'b0, exp});
    // Operands are only sampled on accept; scribbling them now must not matter
    bus.opdata1_i = ~a;
    bus.opdata2_i = 32'd0;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #2;
      check_eq({tag, "_hold"}, outs(), {1'b1, 1'b0, exp});
    end
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    @(posedge clk); #2;
    check_eq({tag, "_release"}, outs(), 66'd0);
  endtask

  initial begin
    int ok_cycles;
    n_checks      = 0;
    n_errors      = 0;
    resetn        = 1'b0;
    bus.start_i   = 1'b0;
    bus.signed_i  = 1'b0;
    bus.opdata1_i = 32'd0;
    bus.opdata2_i = 32'd0;
    bus.annul_i   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_outs", outs(), 66'd0);
    check_eq("reset_state", 66'(dut.state_q), 66'(DIV_FREE));
    resetn = 1'b1;
    @(posedge clk); #2;
    check_eq("idle_outs", outs(), 66'd0);

    do_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 0);
    do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 0);
    do_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33, 0);
    do_div("divu_by0", 1'b0, 32'd5, 32'd0, 64'd0, 2, 0);
    do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 33, 0);
    do_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 33, 0);
    do_div("divu_hold", 1'b0, 32'd1000, 32'd10, {32'd0, 32'd100}, 33, 3);

    // Flush at cycle 10, then a fresh request at cycle 11
    @(posedge clk); #1;
    bus.start_i   = 1'b1;
    bus.signed_i  = 1'b0;
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    repeat (10) @(posedge clk);
    #1;
    bus.annul_i = 1'b1;
    #1;
    check_eq("annul_outs", outs(), 66'd0);
    @(posedge clk); #1;
    bus.annul_i   = 1'b0;
    bus.opdata1_i = 32'd9;
    bus.opdata2_i = 32'd3;
    #1;
    check_eq("annul_idle", 66'(dut.state_q), 66'(DIV_FREE));
    check_eq("annul_restart_stall", 66'(bus.stall_o), 66'd1);
    ok_cycles = 0;
    for (int c = 12; c < 44; c++) begin
      @(posedge clk); #2;
      if (bus.stall_o && !bus.ready_o) ok_cycles++;
    end
    check_eq("annul_busy", 66'(ok_cycles), 66'd32);
    @(posedge clk); #2;
    check_eq("annul_result", outs(), {1'b1, 1'b0, 32'd0, 32'd3});
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    @(posedge clk); #2;
    check_eq("annul_release", outs(), 66'd0);

    // Reset in the middle of an operation
    @(posedge clk); #1;
    bus.start_i   = 1'b1;
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    repeat (20) @(posedge clk);
    #1;
    resetn      = 1'b0;
    bus.start_i = 1'b0;
    #1;
    check_eq("midreset_outs", outs(), 66'd0);
    check_eq("midreset_state", 66'(dut.state_q), 66'(DIV_FREE));
    check_eq("midreset_cnt", 66'(dut.cnt_q), 66'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    do_div("divu_after_reset", 1'b0, 32'hFFFF_FFFF, 32'h10, {32'hF, 32'h0FFF_FFFF}, 33, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
